// File: rtl/fsub_pipe.sv
// Pipelined IEEE-754 binary32 subtractor y = x1 - x2 with valid/ready handshakes
// and a global stall. Optional exponent-overflow saturation under FSUB_OVF_EN.
module fsub_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
`ifdef FSUB_OVF_EN
    ,
    output logic        ovf
`endif
);

    logic        stall_s;
    logic        adv_s;

    // Operand capture rank so the align logic starts from flops.
    logic        s0_valid_r;
    logic [31:0] s0_x1_r;
    logic [31:0] s0_x2_r;

    logic [31:0] x2n_s;
    logic [31:0] big_s;
    logic [31:0] small_s;
    logic [7:0]  exp_l_s;
    logic [7:0]  dist_s;
    logic [27:0] frac_l_s;
    logic [27:0] frac_sm_raw_s;
    logic [27:0] frac_sm_s;
    logic [27:0] lost_mask_s;
    logic        op_sub_s;

    logic        s1_valid_r;
    logic [27:0] s1_frac_l_r;
    logic [27:0] s1_frac_s_r;
    logic [7:0]  s1_exp_l_r;
    logic        s1_sign_r;
    logic        s1_sub_r;

    logic [27:0] sum_s;
    logic [4:0]  lz_s;

    logic        s2_valid_r;
    logic [27:0] s2_sum_r;
    logic [4:0]  s2_lz_r;
    logic [7:0]  s2_exp_l_r;
    logic        s2_sign_r;
    logic        s2_sub_r;

    logic [27:0]       norm_s;
    logic signed [9:0] exp_norm_s;
    logic signed [9:0] exp_fin_s;
    logic              rnd_inc_s;
    logic [24:0]       mant_rnd_s;
    logic [31:0]       y_nx_s;
`ifdef FSUB_OVF_EN
    logic              ovf_nx_s;
`endif
    logic              unused_s;

    assign stall_s  = out_valid & ~out_ready;
    assign adv_s    = ~stall_s;
    assign in_ready = ~stall_s;

    // S1: swap to larger magnitude, build working fields, align the small operand.
    always_comb begin
        x2n_s = {~s0_x2_r[31], s0_x2_r[30:0]};
        if (x2n_s[30:0] > s0_x1_r[30:0]) begin
            big_s   = x2n_s;
            small_s = s0_x1_r;
        end else begin
            big_s   = s0_x1_r;
            small_s = x2n_s;
        end
        exp_l_s = big_s[30:23];
        dist_s  = big_s[30:23] - small_s[30:23];
        if (big_s[30:23] == 8'd0) begin
            frac_l_s = 28'd0;
        end else begin
            frac_l_s = {1'b0, 1'b1, big_s[22:0], 3'b000};
        end
        if (small_s[30:23] == 8'd0) begin
            frac_sm_raw_s = 28'd0;
        end else begin
            frac_sm_raw_s = {1'b0, 1'b1, small_s[22:0], 3'b000};
        end
        lost_mask_s = 28'd0;
        if (dist_s >= 8'd27) begin
            frac_sm_s = {27'd0, |frac_sm_raw_s};
        end else begin
            lost_mask_s  = ~({28{1'b1}} << dist_s);
            frac_sm_s    = frac_sm_raw_s >> dist_s;
            frac_sm_s[0] = frac_sm_s[0] | (|(frac_sm_raw_s & lost_mask_s));
        end
        op_sub_s = big_s[31] ^ small_s[31];
    end

    // S2: add or subtract the aligned fields and count leading zeros over [26:0].
    always_comb begin
        if (s1_sub_r) begin
            sum_s = s1_frac_l_r - s1_frac_s_r;
        end else begin
            sum_s = s1_frac_l_r + s1_frac_s_r;
        end
        lz_s = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            lz_s = sum_s[i] ? 5'(26 - i) : lz_s;
        end
    end

    // S3: normalize, round to nearest even, flush underflow, pack.
    always_comb begin
        if (!s2_sub_r && s2_sum_r[27]) begin
            norm_s     = {1'b0, s2_sum_r[27:2], s2_sum_r[1] | s2_sum_r[0]};
            exp_norm_s = $signed({2'b00, s2_exp_l_r}) + 10'sd1;
        end else begin
            norm_s     = s2_sum_r << s2_lz_r;
            exp_norm_s = $signed({2'b00, s2_exp_l_r}) - $signed({5'd0, s2_lz_r});
        end
        rnd_inc_s  = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_rnd_s = {1'b0, norm_s[26:3]} + {24'd0, rnd_inc_s};
        // A rounding carry leaves the fraction bits at zero, i.e. mantissa 1.0.
        if (mant_rnd_s[24]) begin
            exp_fin_s = exp_norm_s + 10'sd1;
        end else begin
            exp_fin_s = exp_norm_s;
        end
`ifdef FSUB_OVF_EN
        ovf_nx_s = 1'b0;
`endif
        if (s2_sum_r == 28'd0) begin
            y_nx_s = 32'h0000_0000;
        end else if (exp_fin_s <= 10'sd0) begin
            y_nx_s = 32'h0000_0000;
`ifdef FSUB_OVF_EN
        end else if (exp_fin_s >= 10'sd255) begin
            y_nx_s   = {s2_sign_r, 8'hFF, 23'd0};
            ovf_nx_s = 1'b1;
`endif
        end else begin
            y_nx_s = {s2_sign_r, exp_fin_s[7:0], mant_rnd_s[22:0]};
        end
    end

    assign unused_s = ^{norm_s[27], mant_rnd_s[23]};

    // Valid bits: advance as a whole unless the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_r <= 1'b0;
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            out_valid  <= 1'b0;
        end else if (adv_s) begin
            s0_valid_r <= in_valid;
            s1_valid_r <= s0_valid_r;
            s2_valid_r <= s1_valid_r;
            out_valid  <= s2_valid_r;
        end
    end

    // Stage data registers; they hold together with the valid bits on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_x1_r     <= 32'd0;
            s0_x2_r     <= 32'd0;
            s1_frac_l_r <= 28'd0;
            s1_frac_s_r <= 28'd0;
            s1_exp_l_r  <= 8'd0;
            s1_sign_r   <= 1'b0;
            s1_sub_r    <= 1'b0;
            s2_sum_r    <= 28'd0;
            s2_lz_r     <= 5'd0;
            s2_exp_l_r  <= 8'd0;
            s2_sign_r   <= 1'b0;
            s2_sub_r    <= 1'b0;
        end else if (adv_s) begin
            s0_x1_r     <= x1;
            s0_x2_r     <= x2;
            s1_frac_l_r <= frac_l_s;
            s1_frac_s_r <= frac_sm_s;
            s1_exp_l_r  <= exp_l_s;
            s1_sign_r   <= big_s[31];
            s1_sub_r    <= op_sub_s;
            s2_sum_r    <= sum_s;
            s2_lz_r     <= lz_s;
            s2_exp_l_r  <= s1_exp_l_r;
            s2_sign_r   <= s1_sign_r;
            s2_sub_r    <= s1_sub_r;
        end
    end

    // Output registers load only for a real result, so y stays put across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= 32'd0;
`ifdef FSUB_OVF_EN
            ovf <= 1'b0;
`endif
        end else if (adv_s && s2_valid_r) begin
            y <= y_nx_s;
`ifdef FSUB_OVF_EN
            ovf <= ovf_nx_s;
`endif
        end
    end

endmodule

// File: tb/tb_fsub_pipe.sv
// Directed self-checking bench for fsub_pipe: latency, rounding, cancellation,
// flush, backpressure, mid-flight reset and the FSUB_OVF_EN overflow path.
module tb_fsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
`ifdef FSUB_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fsub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
`ifdef FSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated operation: checks acceptance, 3-cycle latency, result and flag.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_y, input logic exp_ovf);
        int cnt;
        @(negedge clk);
        x1 = a; x2 = b; in_valid = 1'b1; out_ready = 1'b1;
        check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check_eq({tag, "_lat"}, cnt, 32'd3);
        check_eq(tag, y, exp_y);
`ifdef FSUB_OVF_EN
        check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
        if (exp_ovf !== 1'b0 && exp_ovf !== 1'b1) $display("note: odd ovf expectation");
`endif
    endtask

    logic [31:0] bp_a   [4];
    logic [31:0] bp_b   [4];
    logic [31:0] bp_exp [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x1 = 32'd0; x2 = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_y", y, 32'd0);
`ifdef FSUB_OVF_EN
        check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;

        run_op("sub_3m1",    32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        run_op("cancel",     32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0);
        run_op("eff_add",    32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0);
        run_op("norm_1ulp",  32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF, 1'b0);
        run_op("tie_even",   32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 1'b0);
        run_op("sub_2m05",   32'h4000_0000, 32'h3F00_0000, 32'h3FC0_0000, 1'b0);
        run_op("neg_swap",   32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 1'b0);
        run_op("zero_x1",    32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 1'b0);
        run_op("sticky_far", 32'h40A0_0000, 32'h3080_0000, 32'h40A0_0000, 1'b0);
        run_op("uflow",      32'h0080_0000, 32'h00C0_0000, 32'h0000_0000, 1'b0);
`ifdef FSUB_OVF_EN
        run_op("ovf",        32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1);
`else
        run_op("ovf_wrap",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7FFF_FFFF, 1'b0);
`endif

        // Backpressure: four back-to-back ops, consumer stalls 5 cycles.
        bp_a[0] = 32'h4040_0000; bp_b[0] = 32'h3F80_0000; bp_exp[0] = 32'h4000_0000;
        bp_a[1] = 32'h4000_0000; bp_b[1] = 32'h3F00_0000; bp_exp[1] = 32'h3FC0_0000;
        bp_a[2] = 32'h3F80_0000; bp_b[2] = 32'h4040_0000; bp_exp[2] = 32'hC000_0000;
        bp_a[3] = 32'h3F80_0000; bp_b[3] = 32'h3380_0000; bp_exp[3] = 32'h3F7F_FFFF;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x1 = bp_a[i]; x2 = bp_b[i]; in_valid = 1'b1;
            check_eq("bp_accept", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_stall_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_stall_ready", {31'd0, in_ready}, 32'd0);
            check_eq("bp_stall_y", y, bp_exp[0]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                if (idx < 4) begin
                    check_eq("bp_order", y, bp_exp[idx]);
                end else begin
                    check_eq("bp_extra", 32'd1, 32'd0);
                end
                idx++;
            end
            @(negedge clk);
        end
        check_eq("bp_count", idx, 32'd4);

        // Reset while two ops are in flight: nothing may emerge afterwards.
        x1 = 32'h4040_0000; x2 = 32'h3F80_0000; in_valid = 1'b1;
        @(negedge clk);
        x1 = 32'h4000_0000; x2 = 32'h3F00_0000;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_y", y, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check_eq("mid_rst_stale", seen, 32'd0);

        run_op("post_rst", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fsub_pipe.md
# fsub_pipe

Pipelined IEEE-754 single-precision subtractor computing `y = x1 - x2`, with valid/ready handshakes on both sides. It is the subtract-side companion to the combinational adder in the FPU. It sits between the FPU issue port and the FP writeback path. Alignment, add/sub, normalize and round are split into three registered stages so the FPU can close timing at core clock.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand pair presented.
- `in_ready`  out  1  block accepts the operand pair this cycle.
- `x1`  in  32  minuend (IEEE-754 binary32).
- `x2`  in  32  subtrahend (IEEE-754 binary32).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result this cycle.
- `y`  out  32  result.
- `ovf`  out  1  exponent overflow flag. Present only under `FSUB_OVF_EN`.

## Operation
- Subtraction is addition with `x2[31]` inverted.
- Operands with exponent 0 are treated as signed zero (denormals flushed). NaN and Inf inputs are not supported; their output is unspecified.
- Stage S1, align:
  - Swap the operands so the larger magnitude (`[30:0]` compare; ties keep x1) becomes L.
  - Compute `d = expL - expS`, 8 bits unsigned.
  - Build a 28-bit working field for each operand: `{carry, hidden, frac[22:0], G, R, S}`.
  - Right-shift the small operand by `d`. S is the OR of all bits shifted out. For `d >= 27`, the small operand reduces to S only.
  - Effective op is add if the signs (after inverting x2) match, otherwise subtract.
- Stage S2, add/sub:
  - 28-bit sum or difference `fL ± fS`.
  - Leading-zero count `lz` over bits [26:0], 0..27.
  - Register the sum, `lz`, `expL`, signL and the op.
- Stage S3, normalize, round and pack:
  - If carry = 1: shift right by 1, folding the dropped bit into S, and `exp = expL + 1`.
  - Otherwise: shift left by `lz` and `exp = expL - lz`.
  - Rounding is round-to-nearest-even: increment the 24-bit mantissa when `G && (R || S || LSB)`. A rounding carry-out sets the mantissa to 1.0 and adds 1 to `exp`.
  - Exact cancellation (sum = 0) gives `y = 0x00000000` (+0).
  - `exp <= 0` (computed in 10-bit signed) gives +0 (flush).
  - Sign of the result is signL.
- Handshake: global stall.
  - `stall = out_valid && !out_ready`.
  - `in_ready = !stall`.
  - When stalled, all stage registers and valid bits hold.
  - A transfer happens on any cycle with `in_valid && in_ready`.
- Reset values: `out_valid=0`, `y=0`, `ovf=0`, all internal valid bits 0, `in_ready=1`.
- Reset asserted mid-operation discards every in-flight operation. Nothing is emitted after reset.

## Timing
- Latency is 3 cycles. An operand accepted at edge N appears with `out_valid=1` after edge N+3, provided no stall occurs.
- Throughput is 1 result per cycle while `out_ready=1`.
- Bubbles do not collapse. An empty stage still advances only when not stalled.
- `y` and `ovf` are registered outputs and stay stable while `out_valid && !out_ready`.
- Results leave in acceptance order. No result is dropped or duplicated.
- `in_ready` depends combinationally on `out_ready` only.

## Configuration
- Macro: `FSUB_OVF_EN`.
- Defined:
  - The `ovf` port exists.
  - When the final `exp >= 255`, `y = {sign, 8'hFF, 23'h0}` (signed Inf) and `ovf=1` for that result.
  - `ovf=0` on every other result.
- Undefined:
  - No `ovf` port.
  - The exponent is truncated to 8 bits; the wrapped encoding is output unchanged.

## Test plan
1. Basic subtract: `x1=0x40400000` (3.0), `x2=0x3F800000` (1.0), `out_ready=1` -> `y=0x40000000` with `out_valid` high exactly 3 cycles after acceptance.
2. Cancellation: `0x3F800000 - 0x3F800000` -> `y=0x00000000`. Separately, `0x3F800000 - 0xBF800000` -> `y=0x40000000` (effective add).
3. Normalize and rounding: `0x3F800000 - 0x33800000` (1 - 2^-24) -> `0x3F7FFFFF`. Separately, `0x3F800000 - 0x33000000` (tie case) -> `0x3F800000`, rounding to even.
4. Backpressure: issue 4 back-to-back ops and hold `out_ready=0` for 5 cycles from the first `out_valid`.
   - `in_ready=0` during the stall.
   - `y` is held stable.
   - On release, all 4 results arrive in order with none lost.
5. Reset mid-flight: accept 2 ops, assert `rst` for 1 cycle before the first result -> `out_valid=0` afterwards, and no stale result appears later.
6. Overflow: `0x7F7FFFFF - 0xFF7FFFFF`.
   - With `FSUB_OVF_EN`: `y=0x7F800000` and `ovf=1`.
   - Without it: the wrapped exponent is output and there is no `ovf` port.
